serial_master: RTL
==================

Name: serial_master

Overview:
Host-side initiator for the single-wire daisychain protocol served by serial_ctrl. Accepts one operation at a time over a valid/ready interface: RESET, WRITE, UPDATE or READ. It serialises a start bit, the command and any write data onto the shared line. For READ it releases the line, samples the data returned by serial_ctrl and presents it as a parallel word. It sits between register/host logic and the chip-level bidirectional pad; the tristate buffer lives in the top level.

Parameters:
CMD_LEN, `CMD_LEN, command width in bits.
DATA_LEN, `DATA_LEN, data word width in bits.
GAP_CYCLES, 1, idle-low cycles between command tail and first WRITE data bit.
TURN_CYCLES, 3, cycles with line released before the first READ sample.
INTER_CYCLES, 2, driven-low cycles after any operation before cmd_ready reasserts.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset, synchronous, active-high.
cmd_valid  in  1  operation request.
cmd_ready  out  1  master can accept an operation.
cmd_op  in  2  master_op_t: OP_RESET, OP_WRITE, OP_UPDATE, OP_READ.
wr_data  in  DATA_LEN  data for OP_WRITE; captured at handshake.
rd_data  out  DATA_LEN  word returned by OP_READ; held until the next READ completes.
rd_valid  out  1  one-cycle pulse when rd_data is updated.
busy  out  1  high from handshake until cmd_ready reasserts.
line_o  out  1  value driven onto the line.
line_oe  out  1  1 = master drives the line; 0 = released.
line_i  in  1  line value as seen at the pad.

Behaviour:
- Reset: state IDLE; cmd_ready=1, busy=0, rd_valid=0, rd_data=0, line_oe=1, line_o=0. Reset mid-operation aborts immediately and returns to these values on the next edge. No partial rd_valid is issued.
- Handshake: transfer when cmd_valid && cmd_ready. cmd_op and wr_data are registered. cmd_ready drops the following cycle. cmd_valid is ignored while busy.
- All line outputs are registered, one bit per clk. Bit order is MSB first for both command and data.
- Command mapping: OP_RESET→RESET_CMD, OP_WRITE→START_RCV_CMD, OP_UPDATE→UPDATE_CMD, OP_READ→START_SND_CMD.
- States and transitions:
  - IDLE → START: line_o=1 for 1 cycle.
  - START → CMD: CMD_LEN cycles.
  - CMD → CMD_TAIL: line_o=0, 1 cycle.
  - CMD_TAIL, OP_WRITE → GAP: GAP_CYCLES cycles, low.
  - GAP → DATA_TX: DATA_LEN cycles.
  - DATA_TX → DATA_TAIL: 1 cycle, low.
  - DATA_TAIL → INTER.
  - CMD_TAIL, OP_READ → TURN: line_oe=0 for TURN_CYCLES cycles.
  - TURN → DATA_RX: line_oe=0. line_i is sampled on each of DATA_LEN consecutive edges into a shift register.
  - DATA_RX → INTER: line_oe reasserts with line_o=0. rd_data and rd_valid are updated on the same edge.
  - CMD_TAIL, OP_RESET/OP_UPDATE → INTER.
  - INTER: INTER_CYCLES cycles, low → IDLE, with cmd_ready=1.
- A single bit counter covers CMD, GAP, DATA_TX, TURN, DATA_RX and INTER. Its width is $clog2 of the maximum of the lengths plus 1. No wrap: it is reloaded on every state entry.
- Back-to-back: a handshake in the same cycle cmd_ready reasserts is legal. START then follows on the next edge.
- line_oe=0 only in TURN and DATA_RX.

Optional Feature:
SERIAL_MASTER_AUTO_UPDATE_EN.
- Defined: after OP_WRITE's INTER phase completes, the master automatically issues a full UPDATE sequence (START, CMD=UPDATE_CMD, CMD_TAIL, INTER) before cmd_ready reasserts. busy stays high throughout.
- Undefined: OP_WRITE ends after its INTER phase; the host must issue OP_UPDATE explicitly.

Decomposition:
- Shared package serial_pkg:
  - ctrl_cmd_t and the command constants RESET_CMD, START_RCV_CMD, UPDATE_CMD, START_SND_CMD.
  - CMD_LEN and DATA_LEN.
  - master_op_t.
  - master_state_t.
- One natural sub-module: serial_master_shifter, a loadable/shiftable DATA_LEN register shared by TX (parallel load, shift out MSB) and RX (shift in at LSB).

Test Plan:
- Reset then OP_RESET: line reads 1, RESET_CMD bits MSB first, 0, then 2 low cycles. cmd_ready returns exactly 2+CMD_LEN+INTER_CYCLES cycles after the handshake.
- OP_WRITE wr_data=8'hA5 into serial_ctrl: line reads 1, START_RCV_CMD, 0, 0, 1,0,1,0,0,1,0,1, 0. Then OP_UPDATE → serial_ctrl bit_out reversed equals 8'hA5.
- OP_READ after writing 8'h3C: line_oe=0 for exactly 3+DATA_LEN cycles, rd_data=8'h3C, rd_valid high for one cycle. Sweep 0..255 with 0 mismatches.
- cmd_valid held high while busy with a different cmd_op → ignored. The op that completes matches the one captured at handshake.
- rst asserted mid-DATA_RX → next cycle line_oe=1, line_o=0, cmd_ready=1, no rd_valid pulse, rd_data unchanged at 0.
- With SERIAL_MASTER_AUTO_UPDATE_EN: OP_WRITE 8'hFF → UPDATE_CMD follows without host action, and serial_ctrl bit_out=all ones before cmd_ready reasserts.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the single-wire daisychain master.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
`ifndef CMD_LEN
`define CMD_LEN 4
`endif
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package serial_pkg;

  localparam int CMD_LEN  = `CMD_LEN;
  localparam int DATA_LEN = `DATA_LEN;

  typedef logic [CMD_LEN-1:0] ctrl_cmd_t;

  // Command codes understood by serial_ctrl, sent MSB first.
  localparam ctrl_cmd_t RESET_CMD     = ctrl_cmd_t'(4'b1101);
  localparam ctrl_cmd_t START_RCV_CMD = ctrl_cmd_t'(4'b1010);
  localparam ctrl_cmd_t UPDATE_CMD    = ctrl_cmd_t'(4'b1100);
  localparam ctrl_cmd_t START_SND_CMD = ctrl_cmd_t'(4'b1011);

  typedef enum logic [1:0] {
    OP_RESET  = 2'd0,
    OP_WRITE  = 2'd1,
    OP_UPDATE = 2'd2,
    OP_READ   = 2'd3
  } master_op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_CMD_TAIL,
    ST_GAP,
    ST_DATA_TX,
    ST_DATA_TAIL,
    ST_TURN,
    ST_DATA_RX,
    ST_INTER
  } master_state_t;

  // Host operation to the command word placed on the line.
  function automatic ctrl_cmd_t op_to_cmd(input master_op_t op);
    ctrl_cmd_t c;
    case (op)
      OP_RESET:  c = RESET_CMD;
      OP_WRITE:  c = START_RCV_CMD;
      OP_UPDATE: c = UPDATE_CMD;
      OP_READ:   c = START_SND_CMD;
      default:   c = RESET_CMD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_master_if.sv
// Host-side operation bundle for serial_master.
// Latency: none, this is wiring only.
// Backpressure: cmd_ready from the master gates cmd_valid; busy mirrors !cmd_ready.
interface serial_master_if;
  import serial_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  master_op_t          cmd_op;
  logic [DATA_LEN-1:0] wr_data;
  logic [DATA_LEN-1:0] rd_data;
  logic                rd_valid;
  logic                busy;

  modport master (
    input  cmd_valid, cmd_op, wr_data,
    output cmd_ready, rd_data, rd_valid, busy
  );

  modport slave (
    output cmd_valid, cmd_op, wr_data,
    input  cmd_ready, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/serial_master_shifter.sv
// Data shift register shared by transmit (parallel load, MSB out) and receive (LSB in).
// Latency: one clock per load or shift.
// Backpressure: none; the controlling FSM decides when to load or shift.
module serial_master_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sh_q;

  // Load has priority; a shift moves everything towards the MSB end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= load_dat_i;
    end else if (shift_i) begin
      sh_q <= {sh_q[WIDTH-2:0], shift_in_i};
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/serial_master.sv
// Single-wire daisychain initiator: one RESET/WRITE/UPDATE/READ op at a time, line bits registered.
// Latency: START bit one cycle after handshake; op length fixed by op type (see FSM).
// Backpressure: cmd_ready low from handshake until the INTER phase ends. Optional SERIAL_MASTER_AUTO_UPDATE_EN.
module serial_master
  import serial_pkg::*;
#(
  parameter int GAP_CYCLES   = 1,
  parameter int TURN_CYCLES  = 3,
  parameter int INTER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  serial_master_if.master  host,
  output logic             line_o,
  output logic             line_oe,
  input  logic             line_i
);

  localparam int MAX_A   = (CMD_LEN > DATA_LEN) ? CMD_LEN : DATA_LEN;
  localparam int MAX_B   = (GAP_CYCLES > TURN_CYCLES) ? GAP_CYCLES : TURN_CYCLES;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LEN = (MAX_C > INTER_CYCLES) ? MAX_C : INTER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTER_CYCLES - 1);

  master_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  ctrl_cmd_t           cmd_q, cmd_d;
  master_op_t          op_q, op_d;
  logic                line_o_q, line_o_d;
  logic                line_oe_q, line_oe_d;
  logic [DATA_LEN-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                sh_load, sh_shift, sh_in;
  logic [DATA_LEN-1:0] sh_q;

`ifdef SERIAL_MASTER_AUTO_UPDATE_EN
  logic                auto_q, auto_d;
`endif

  serial_master_shifter #(.WIDTH(DATA_LEN)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sh_load),
    .load_dat_i (host.wr_data),
    .shift_i    (sh_shift),
    .shift_in_i (sh_in),
    .q_o        (sh_q)
  );

  // Next state, counter reload and the line value for the coming cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    op_d       = op_q;
    line_o_d   = 1'b0;
    line_oe_d  = 1'b1;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_in      = 1'b0;
`ifdef SERIAL_MASTER_AUTO_UPDATE_EN
    auto_d     = auto_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          op_d     = host.cmd_op;
          cmd_d    = op_to_cmd(host.cmd_op);
          sh_load  = 1'b1;
          line_o_d = 1'b1;
          state_d  = ST_START;
`ifdef SERIAL_MASTER_AUTO_UPDATE_EN
          auto_d   = (host.cmd_op == OP_WRITE);
`endif
        end
      end
      ST_START: begin
        state_d  = ST_CMD;
        cnt_d    = CMD_LAST;
        line_o_d = cmd_q[CMD_LEN-1];
        cmd_d    = {cmd_q[CMD_LEN-2:0], 1'b0};
      end
      ST_CMD: begin
        if (cnt_q == '0) begin
          state_d = ST_CMD_TAIL;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          line_o_d = cmd_q[CMD_LEN-1];
          cmd_d    = {cmd_q[CMD_LEN-2:0], 1'b0};
        end
      end
      ST_CMD_TAIL: begin
        case (op_q)
          OP_WRITE: begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end
          OP_READ: begin
            state_d   = ST_TURN;
            cnt_d     = TURN_LAST;
            line_oe_d = 1'b0;
          end
          default: begin
            state_d = ST_INTER;
            cnt_d   = INTER_LAST;
          end
        endcase
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d  = ST_DATA_TX;
          cnt_d    = DATA_LAST;
          line_o_d = sh_q[DATA_LEN-1];
          sh_shift = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA_TX: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA_TAIL;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          line_o_d = sh_q[DATA_LEN-1];
          sh_shift = 1'b1;
        end
      end
      ST_DATA_TAIL: begin
        state_d = ST_INTER;
        cnt_d   = INTER_LAST;
      end
      ST_TURN: begin
        line_oe_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_DATA_RX;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA_RX: begin
        sh_shift = 1'b1;
        sh_in    = line_i;
        if (cnt_q == '0) begin
          // Last sample goes straight into rd_data together with the pulse.
          state_d    = ST_INTER;
          cnt_d      = INTER_LAST;
          rd_data_d  = {sh_q[DATA_LEN-2:0], line_i};
          rd_valid_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          line_oe_d = 1'b0;
        end
      end
      ST_INTER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef SERIAL_MASTER_AUTO_UPDATE_EN
          // A finished WRITE chains straight into an UPDATE without releasing busy.
          if (auto_q) begin
            auto_d   = 1'b0;
            op_d     = OP_UPDATE;
            cmd_d    = UPDATE_CMD;
            line_o_d = 1'b1;
            state_d  = ST_START;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered line/host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      op_q       <= OP_RESET;
      line_o_q   <= 1'b0;
      line_oe_q  <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      op_q       <= op_d;
      line_o_q   <= line_o_d;
      line_oe_q  <= line_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SERIAL_MASTER_AUTO_UPDATE_EN
  // Pending automatic UPDATE after a WRITE.
  always_ff @(posedge clk) begin
    if (rst) auto_q <= 1'b0;
    else     auto_q <= auto_d;
  end
`endif

  assign host.cmd_ready = (state_q == ST_IDLE);
  assign host.busy      = (state_q != ST_IDLE);
  assign host.rd_data   = rd_data_q;
  assign host.rd_valid  = rd_valid_q;
  assign line_o         = line_o_q;
  assign line_oe        = line_oe_q;

endmodule
